// File: rtl/minirv_pkg.sv
// Shared definitions for the multi-cycle miniRV core: opcode/funct3 encodings,
// FSM state and writeback-select enums, and immediate decode helpers.
package minirv_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  // Sign-extended 12-bit I-type immediate.
  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  // Sign-extended 12-bit S-type immediate.
  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

endpackage

// File: rtl/minirv_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// x0 and any index >= NUM_REGS read as zero and are never written.
module minirv_regfile
  import minirv_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] i_raddr1,
  output logic [31:0]       o_rdata1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [31:0]       o_rdata2,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [31:0]       i_wdata
);

  // Full 32-entry array; entries outside 1..NUM_REGS-1 stay zero forever.
  logic [31:0] r_regs [32];
  logic        w_wr_ok;

  assign w_wr_ok = i_we && (i_waddr != '0) && ({27'b0, i_waddr} < NUM_REGS);

  // Synchronous clear on reset, otherwise a single gated write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/minirv_multicycle.sv
// Multi-cycle miniRV core over one shared req/ready memory port.
// Define MINIRV_TRAP_EN to halt on illegal instructions; otherwise they act as NOPs.
// Memory handshake: a transfer completes on a rising edge where mem_req && mem_ready;
// while mem_req=1 and mem_ready=0 every request field holds, and mem_req never drops
// until the transfer completes (reset excepted).
module minirv_multicycle
  import minirv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        retire,
  output logic        halted,
  output state_t      dbg_state
);

  state_t      r_state, w_next_state;
  logic        r_run;  // low for the cycle right after reset so no request issues during reset
  logic [31:0] r_pc, r_ir, r_ea;

  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [31:0] w_rs1_val, w_rs2_val, w_imm_i, w_imm_s, w_imm_u;
  logic [31:0] w_alu, w_pc4, w_jalr_tgt, w_ea, w_load_data, w_wb_data;
  logic        w_is_r, w_is_i, w_is_lui, w_is_load, w_is_store, w_is_jalr;
  logic        w_mem_op, w_legal, w_fetch_done, w_mem_done, w_rf_we;
  wb_sel_t     w_wb_sel;

  function automatic logic idx_ok(input logic [4:0] idx);
    return {27'b0, idx} < NUM_REGS;
  endfunction

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];
  assign w_imm_i  = imm_i(r_ir);
  assign w_imm_s  = imm_s(r_ir);
  assign w_imm_u  = {r_ir[31:12], 12'b0};

  minirv_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .i_raddr1 (w_rs1),
    .o_rdata1 (w_rs1_val),
    .i_raddr2 (w_rs2),
    .o_rdata2 (w_rs2_val),
    .i_we     (w_rf_we),
    .i_waddr  (w_rd),
    .i_wdata  (w_wb_data)
  );

  // Instruction classification and legality; only register fields an op uses are range-checked.
  always_comb begin
    w_is_r     = (w_opcode == OP_R) && (w_f3 == F3_ADD) && (w_f7 == 7'b0);
    w_is_i     = (w_opcode == OP_I) && (w_f3 == F3_ADD);
    w_is_lui   = (w_opcode == OP_LUI);
    w_is_load  = (w_opcode == OP_LOAD) && ((w_f3 == F3_LW) || (w_f3 == F3_LBU));
    w_is_store = (w_opcode == OP_STORE) && ((w_f3 == F3_SW) || (w_f3 == F3_SB));
    w_is_jalr  = (w_opcode == OP_JALR) && (w_f3 == F3_JALR);
    w_mem_op   = w_is_load || w_is_store;
    w_legal    = (w_is_r && idx_ok(w_rd) && idx_ok(w_rs1) && idx_ok(w_rs2))
              || ((w_is_i || w_is_load || w_is_jalr) && idx_ok(w_rd) && idx_ok(w_rs1))
              || (w_is_lui && idx_ok(w_rd))
              || (w_is_store && idx_ok(w_rs1) && idx_ok(w_rs2));
  end

  assign w_alu        = w_rs1_val + (w_is_r ? w_rs2_val : w_imm_i);
  assign w_pc4        = r_pc + 32'd4;
  assign w_jalr_tgt   = (w_rs1_val + w_imm_i) & ~32'h1;
  assign w_ea         = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
  assign w_fetch_done = (r_state == ST_FETCH) && r_run && mem_ready;
  assign w_mem_done   = (r_state == ST_MEM) && mem_ready;

  // Writeback select and enable; register writes happen only on a completing cycle.
  always_comb begin
    w_rf_we  = 1'b0;
    w_wb_sel = WB_ALU;
    if ((r_state == ST_EXEC) && w_legal && !w_mem_op) begin
      w_rf_we  = 1'b1;
      w_wb_sel = w_is_lui ? WB_IMM : (w_is_jalr ? WB_PC4 : WB_ALU);
    end else if (w_mem_done && w_is_load) begin
      w_rf_we  = 1'b1;
      w_wb_sel = WB_MEM;
    end
  end

  // Load data alignment: lbu picks byte ea[1:0] and zero-extends.
  always_comb begin
    w_load_data = mem_rdata;
    if (w_f3 == F3_LBU) begin
      case (r_ea[1:0])
        2'd0:    w_load_data = {24'b0, mem_rdata[7:0]};
        2'd1:    w_load_data = {24'b0, mem_rdata[15:8]};
        2'd2:    w_load_data = {24'b0, mem_rdata[23:16]};
        default: w_load_data = {24'b0, mem_rdata[31:24]};
      endcase
    end
    case (w_wb_sel)
      WB_MEM:  w_wb_data = w_load_data;
      WB_PC4:  w_wb_data = w_pc4;
      WB_IMM:  w_wb_data = w_imm_u;
      default: w_wb_data = w_alu;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: if (w_fetch_done) w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (!w_legal) begin
`ifdef MINIRV_TRAP_EN
          w_next_state = ST_HALT;
`else
          w_next_state = ST_FETCH;
`endif
        end else if (w_mem_op) begin
          w_next_state = ST_MEM;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_MEM: if (w_mem_done) w_next_state = ST_FETCH;
      default: begin
`ifdef MINIRV_TRAP_EN
        w_next_state = ST_HALT;
`else
        w_next_state = ST_FETCH;
`endif
      end
    endcase
  end

  // Architectural PC, instruction register and effective-address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_ir  <= '0;
      r_ea  <= '0;
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_fetch_done) r_ir <= mem_rdata;
      if (r_state == ST_EXEC) begin
        if (w_legal) begin
          if (w_is_jalr)     r_pc <= w_jalr_tgt;
          else if (w_mem_op) r_ea <= w_ea;
          else               r_pc <= w_pc4;
        end else begin
`ifdef MINIRV_TRAP_EN
          r_pc <= r_pc;  // stays on the offending instruction
`else
          r_pc <= w_pc4;
`endif
        end
      end
      if (w_mem_done) r_pc <= w_pc4;
    end
  end

  // FSM outputs: memory request fields and the retire pulse.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    retire    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req  = r_run;
        mem_addr = r_run ? {r_pc[31:2], 2'b00} : 32'h0;
      end
      ST_EXEC: begin
`ifdef MINIRV_TRAP_EN
        retire = w_legal && !w_mem_op;
`else
        retire = !(w_legal && w_mem_op);
`endif
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = {r_ea[31:2], 2'b00};
        retire   = mem_ready;
        if (w_is_store) begin
          mem_we = 1'b1;
          if (w_f3 == F3_SW) begin
            mem_wstrb = 4'b1111;
            mem_wdata = w_rs2_val;
          end else begin
            mem_wstrb = 4'b0001 << r_ea[1:0];
            mem_wdata = {4{w_rs2_val[7:0]}};
          end
        end
      end
      default: ;
    endcase
  end

`ifdef MINIRV_TRAP_EN
  assign halted = (r_state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  assign dbg_state = r_state;

endmodule

// File: tb/tb_minirv_multicycle.sv
// Directed bench for minirv_multicycle (RESET_PC=0x100): program image in a
// behavioural memory, write/fetch scoreboards, stall, illegal-op and reset steps.
module tb_minirv_multicycle;
  import minirv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  state_t      dbg_state;

  logic [31:0] mem [0:1023];
  logic        ready_en;
  int          checks = 0;
  int          errors = 0;
  logic [67:0] w_exp_q[$];  // {addr, wstrb, wdata} of expected writes, in order
  logic [31:0] f_exp_q[$];  // expected completed fetch addresses, in order

  minirv_multicycle #(.RESET_PC(32'h100), .NUM_REGS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .retire    (retire),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  assign mem_ready = ready_en;
  assign mem_rdata = mem[mem_addr[11:2]];

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fetch(input logic [31:0] addr, input int max);
    int n;
    n = 0;
    while (!(dbg_state == ST_FETCH && mem_req && mem_addr == addr) && n < max) begin
      step();
      n++;
    end
    chk($sformatf("reach_fetch_%0h", addr), {67'b0, n < max}, 68'd1);
  endtask

  // Instruction encoders
  function automatic logic [31:0] i_ty(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_ty(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return i_ty(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return i_ty(imm, rs1, 3'b000, rd, 7'b1100111);
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[11:2]] = word;
  endtask

  // Scoreboard: completed writes update memory and are matched against w_exp_q;
  // completed fetches are matched against f_exp_q.
  always @(posedge clk) begin
    if (!reset && mem_req && mem_ready) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[11:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
        if (w_exp_q.size() == 0) chk("write_expected", 68'd0, 68'd1);
        else chk("mem_write", {mem_addr, mem_wstrb, mem_wdata}, w_exp_q.pop_front());
      end else if (dbg_state == ST_FETCH) begin
        if (f_exp_q.size() == 0) chk("fetch_expected", 68'd0, 68'd1);
        else chk("fetch_addr", {36'b0, mem_addr}, {36'b0, f_exp_q.pop_front()});
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    put(32'h100, addi(5'd1, 5'd0, 12'd5));                         // addi x1,x0,5
    put(32'h104, {7'b0, 5'd1, 5'd1, 3'b000, 5'd2, 7'b0110011});    // add x2,x1,x1
    put(32'h108, {20'h12345, 5'd3, 7'b0110111});                   // lui x3,0x12345
    put(32'h10C, addi(5'd0, 5'd0, 12'd7));                         // addi x0,x0,7
    put(32'h110, s_ty(12'h300, 5'd2, 5'd0, 3'b010));               // sw x2,0x300(x0)
    put(32'h114, s_ty(12'h304, 5'd3, 5'd0, 3'b010));               // sw x3,0x304(x0)
    put(32'h118, s_ty(12'h308, 5'd0, 5'd0, 3'b010));               // sw x0,0x308(x0)
    put(32'h11C, addi(5'd4, 5'd0, 12'h0AB));                       // addi x4,x0,0xAB
    put(32'h120, s_ty(12'h203, 5'd4, 5'd0, 3'b000));               // sb x4,0x203(x0)
    put(32'h124, i_ty(12'h203, 5'd0, 3'b100, 5'd5, 7'b0000011));   // lbu x5,0x203(x0)
    put(32'h128, s_ty(12'h30C, 5'd5, 5'd0, 3'b010));               // sw x5,0x30C(x0)
    put(32'h12C, addi(5'd1, 5'd0, 12'h040));                       // addi x1,x0,0x40
    put(32'h130, jalr(5'd0, 5'd0, 12'h010));                       // jalr x0,x0,0x10
    put(32'h010, jalr(5'd1, 5'd1, 12'd3));                         // jalr x1,x1,3 -> pc 0x42, x1 0x14
    put(32'h040, jalr(5'd5, 5'd0, 12'h080));                       // at pc 0x42: x5=0x46, pc 0x80
    put(32'h080, s_ty(12'h310, 5'd1, 5'd0, 3'b010));               // sw x1,0x310(x0)
    put(32'h084, s_ty(12'h314, 5'd5, 5'd0, 3'b010));               // sw x5,0x314(x0)
    put(32'h088, i_ty(12'h300, 5'd0, 3'b010, 5'd6, 7'b0000011));   // lw x6,0x300(x0)
    put(32'h08C, s_ty(12'h318, 5'd6, 5'd0, 3'b010));               // sw x6,0x318(x0)
    put(32'h090, 32'h0000_007F);                                   // illegal opcode
    put(32'h094, addi(5'd7, 5'd0, 12'd1));

    w_exp_q.push_back({32'h300, 4'hF, 32'h0000_000A});
    w_exp_q.push_back({32'h304, 4'hF, 32'h1234_5000});
    w_exp_q.push_back({32'h308, 4'hF, 32'h0000_0000});
    w_exp_q.push_back({32'h200, 4'h8, 32'hABAB_ABAB});
    w_exp_q.push_back({32'h30C, 4'hF, 32'h0000_00AB});
    w_exp_q.push_back({32'h310, 4'hF, 32'h0000_0014});
    w_exp_q.push_back({32'h314, 4'hF, 32'h0000_0046});
    w_exp_q.push_back({32'h318, 4'hF, 32'h0000_000A});
    for (int a = 32'h100; a <= 32'h130; a += 4) f_exp_q.push_back(32'(a));
    f_exp_q.push_back(32'h010);
    f_exp_q.push_back(32'h040);
    f_exp_q.push_back(32'h080);
    f_exp_q.push_back(32'h084);
    f_exp_q.push_back(32'h088);
    f_exp_q.push_back(32'h08C);
    f_exp_q.push_back(32'h090);
    f_exp_q.push_back(32'h100);  // restart after the final reset

    // Reset
    reset    = 1'b1;
    ready_en = 1'b0;
    step(); step(); step();
    chk("rst_mem_req", {67'b0, mem_req}, 68'd0);
    chk("rst_mem_we", {67'b0, mem_we}, 68'd0);
    chk("rst_mem_addr", {36'b0, mem_addr}, 68'd0);
    chk("rst_mem_wdata", {36'b0, mem_wdata}, 68'd0);
    chk("rst_mem_wstrb", {64'b0, mem_wstrb}, 68'd0);
    chk("rst_retire", {67'b0, retire}, 68'd0);
    chk("rst_halted", {67'b0, halted}, 68'd0);

    // First fetch from RESET_PC, then the 2-cycle ALU retire cadence
    reset = 1'b0;
    step();
    chk("first_fetch", {34'b0, mem_req, mem_we, mem_addr}, {34'b0, 1'b1, 1'b0, 32'h100});
    ready_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("retire_cadence_%0d", i), {67'b0, retire}, 68'(i % 2));
      step();
    end

    // lw stalled five cycles in MEM
    wait_fetch(32'h088, 200);
    step();
    chk("lw_exec", {66'b0, dbg_state}, {66'b0, ST_EXEC});
    ready_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("lw_stall_%0d", i), {29'b0, mem_req, mem_we, mem_addr, mem_wstrb, retire},
          {29'b0, 1'b1, 1'b0, 32'h300, 4'h0, 1'b0});
    end
    ready_en = 1'b1;
    #1;
    chk("lw_complete_retire", {67'b0, retire}, 68'd1);

    // Illegal opcode
    wait_fetch(32'h090, 100);
    step();
`ifdef MINIRV_TRAP_EN
    chk("illegal_no_retire", {67'b0, retire}, 68'd0);
    step();
    chk("trap_halt", {65'b0, halted, mem_req, retire}, {65'b0, 1'b1, 1'b0, 1'b0});
    step(); step(); step();
    chk("trap_sticky", {65'b0, halted, mem_req, retire}, {65'b0, 1'b1, 1'b0, 1'b0});
    chk("trap_pc", {36'b0, dut.r_pc}, {36'b0, 32'h090});
`else
    chk("illegal_nop_retire", {67'b0, retire}, 68'd1);
    step();
    chk("illegal_next_fetch", {35'b0, mem_req, mem_addr}, {35'b0, 1'b1, 32'h094});
    ready_en = 1'b0;
    step(); step();
    chk("fetch_stall_hold", {34'b0, mem_req, mem_addr, retire}, {34'b0, 1'b1, 32'h094, 1'b0});
`endif

    // Reset mid-request (or from HALT) restarts at RESET_PC
    reset    = 1'b1;
    ready_en = 1'b0;
    step();
    chk("rst2_outputs", {64'b0, mem_req, mem_we, halted, retire}, 68'd0);
    reset = 1'b0;
    step();
    chk("rst2_fetch", {34'b0, mem_req, mem_we, mem_addr}, {34'b0, 1'b1, 1'b0, 32'h100});
    ready_en = 1'b1;
    step();
    chk("rst2_first_retire", {67'b0, retire}, 68'd1);
    ready_en = 1'b0;
    step();
    chk("rst2_second_fetch", {34'b0, mem_req, mem_addr, retire}, {34'b0, 1'b1, 32'h104, 1'b0});

    chk("write_q_drained", 68'(w_exp_q.size()), 68'd0);
    chk("fetch_q_drained", 68'(f_exp_q.size()), 68'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
